sprite_color_mapper: RTL and testbench

//  Consumes the 506-entry RGB palette table and converts per-pixel palette indices

---
 rtl/sprite_color_mapper.sv | 147 ++++++++++++++
 tb/tb_sprite_color_mapper.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_color_mapper.sv
// sprite_color_mapper
//   Two-stage colour pipeline between the sprite/map index fetch stage and the
//   VGA DAC pins. Resolves sprite-over-background priority with a colour key,
//   applies a frame-counted flash to flagged sprite pixels, looks up the RGB
//   value in the palette and forces black for blanking, invalid pixels and
//   out-of-range indices. Syncs, blank and valid travel with the colour, so
//   every output lags its input by exactly two clocks.
//
// Ports
//   Clk, Reset_n            pixel clock, async active-low reset
//   frame_start             one-cycle pulse per frame, advances frame counter
//   pix_valid               fg_idx/bg_idx/sync inputs valid this cycle
//   blank_n_in, hs_in, vs_in  raw video timing (hs/vs active low)
//   fg_idx, bg_idx          sprite / background palette indices
//   flash_en                flash request for this sprite pixel
//   palette                 static RGB table, entry [i][0..2] = R,G,B
//   VGA_R/G/B               output colour
//   VGA_BLANK_N/HS/VS       timing delayed to match colour
//   pix_valid_o             pix_valid delayed to match colour
module sprite_color_mapper #(
  parameter int unsigned PAL_DEPTH  = 506,
  parameter int unsigned TRANSP_IDX = 0,
  parameter int unsigned FLASH_BIT  = 3
) (
  input  logic                                  Clk,
  input  logic                                  Reset_n,
  input  logic                                  frame_start,
  input  logic                                  pix_valid,
  input  logic                                  blank_n_in,
  input  logic                                  hs_in,
  input  logic                                  vs_in,
  input  logic [8:0]                            fg_idx,
  input  logic [8:0]                            bg_idx,
  input  logic                                  flash_en,
  input  logic [0:PAL_DEPTH-1][0:2][7:0]        palette,
  output logic [7:0]                            VGA_R,
  output logic [7:0]                            VGA_G,
  output logic [7:0]                            VGA_B,
  output logic                                  VGA_BLANK_N,
  output logic                                  VGA_HS,
  output logic                                  VGA_VS,
  output logic                                  pix_valid_o
);

  localparam logic [8:0] PAL_DEPTH_W = 9'(PAL_DEPTH);
  localparam logic [8:0] TRANSP_W    = 9'(TRANSP_IDX);

  logic [5:0]  frame_cnt_q, frame_cnt_d;

  // Stage 1: layer select and flash decision
  logic [8:0]  sel_idx_q, sel_idx_d;
  logic        flash_q, flash_d;
  logic        blank_n_q, blank_n_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        valid_q, valid_d;
  logic        is_fg;

  // Stage 2: colour and delayed timing
  logic [23:0]         rgb_q, rgb_d;
  logic                blank_n_o_q, blank_n_o_d;
  logic                hs_o_q, hs_o_d;
  logic                vs_o_q, vs_o_d;
  logic                valid_o_q, valid_o_d;
  logic [8:0]          pal_addr;
  logic [0:2][7:0]     pal_entry;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start) frame_cnt_d = frame_cnt_q + 6'd1;

    is_fg     = (fg_idx != TRANSP_W);
    sel_idx_d = is_fg ? fg_idx : bg_idx;
    // Uses the pre-increment count, so a pixel coincident with frame_start
    // still belongs to the old frame.
    flash_d   = flash_en & is_fg & frame_cnt_q[FLASH_BIT];
    blank_n_d = blank_n_in;
    hs_d      = hs_in;
    vs_d      = vs_in;
    valid_d   = pix_valid;
  end

  always_comb begin
    // Out-of-range indices are redirected to entry 0 so the table read never
    // leaves the array; the result is discarded by the priority chain anyway.
    pal_addr  = (sel_idx_q < PAL_DEPTH_W) ? sel_idx_q : '0;
    pal_entry = palette[pal_addr];

    rgb_d = '0;
    if (!blank_n_q || !valid_q) begin
      rgb_d = '0;
    end else if (sel_idx_q >= PAL_DEPTH_W) begin
      rgb_d = '0;
    end else if (flash_q) begin
      rgb_d = 24'hFF_FF_FF;
    end else if (sel_idx_q == TRANSP_W) begin
      // both layers keyed: nothing to show
      rgb_d = '0;
    end else begin
      rgb_d = {pal_entry[0], pal_entry[1], pal_entry[2]};
    end

    blank_n_o_d = blank_n_q;
    hs_o_d      = hs_q;
    vs_o_d      = vs_q;
    valid_o_d   = valid_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      frame_cnt_q <= '0;
      sel_idx_q   <= '0;
      flash_q     <= 1'b0;
      blank_n_q   <= 1'b0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      valid_q     <= 1'b0;
      rgb_q       <= '0;
      blank_n_o_q <= 1'b0;
      hs_o_q      <= 1'b1;
      vs_o_q      <= 1'b1;
      valid_o_q   <= 1'b0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      sel_idx_q   <= sel_idx_d;
      flash_q     <= flash_d;
      blank_n_q   <= blank_n_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      valid_q     <= valid_d;
      rgb_q       <= rgb_d;
      blank_n_o_q <= blank_n_o_d;
      hs_o_q      <= hs_o_d;
      vs_o_q      <= vs_o_d;
      valid_o_q   <= valid_o_d;
    end
  end

  assign VGA_R       = rgb_q[23:16];
  assign VGA_G       = rgb_q[15:8];
  assign VGA_B       = rgb_q[7:0];
  assign VGA_BLANK_N = blank_n_o_q;
  assign VGA_HS      = hs_o_q;
  assign VGA_VS      = vs_o_q;
  assign pix_valid_o = valid_o_q;

endmodule

// File: tb/tb_sprite_color_mapper.sv
// Self-checking bench for sprite_color_mapper. Inputs are driven on the
// falling edge; the expected output word for each driven cycle is pushed to a
// scoreboard queue and popped two falling edges later, when the DUT shows it.
module tb_sprite_color_mapper;

  logic                     Clk = 1'b0;
  logic                     Reset_n;
  logic                     frame_start, pix_valid, blank_n_in, hs_in, vs_in, flash_en;
  logic [8:0]               fg_idx, bg_idx;
  logic [0:505][0:2][7:0]   palette;
  logic [7:0]               VGA_R, VGA_G, VGA_B;
  logic                     VGA_BLANK_N, VGA_HS, VGA_VS, pix_valid_o;

  sprite_color_mapper dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .blank_n_in(blank_n_in), .hs_in(hs_in), .vs_in(vs_in), .fg_idx(fg_idx),
    .bg_idx(bg_idx), .flash_en(flash_en), .palette(palette), .VGA_R(VGA_R),
    .VGA_G(VGA_G), .VGA_B(VGA_B), .VGA_BLANK_N(VGA_BLANK_N), .VGA_HS(VGA_HS),
    .VGA_VS(VGA_VS), .pix_valid_o(pix_valid_o)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic       rst_n, fs, valid, blank_n, hs, vs, fl;
    logic [8:0] fg, bg;
  } stim_t;

  // {R,G,B,BLANK_N,HS,VS,VALID}
  localparam logic [27:0] RST_VEC = {24'h0, 1'b0, 1'b1, 1'b1, 1'b0};

  logic [23:0] pal_m [506];
  logic [27:0] exp_q [$];
  logic [5:0]  cnt_m;
  int          n_pass = 0;
  int          n_total = 0;

  wire [27:0] obs = {VGA_R, VGA_G, VGA_B, VGA_BLANK_N, VGA_HS, VGA_VS, pix_valid_o};

  function automatic stim_t mk(logic rst_n, logic fs, logic valid, logic blank_n,
                               logic hs, logic vs, logic [8:0] fg, logic [8:0] bg, logic fl);
    stim_t s;
    s.rst_n = rst_n; s.fs = fs; s.valid = valid; s.blank_n = blank_n;
    s.hs = hs; s.vs = vs; s.fg = fg; s.bg = bg; s.fl = fl;
    return s;
  endfunction

  function automatic logic [23:0] model_rgb(stim_t s, logic [5:0] cnt);
    logic [8:0] sel;
    if (!s.valid || !s.blank_n) return 24'h0;
    sel = (s.fg != 9'd0) ? s.fg : s.bg;
    if (sel > 9'd505) return 24'h0;
    if (s.fl && s.fg != 9'd0 && cnt[3]) return 24'hFFFFFF;
    if (sel == 9'd0) return 24'h0;
    return pal_m[sel];
  endfunction

  // Apply one cycle of stimulus and record what must appear two cycles later.
  task automatic drive(stim_t s);
    Reset_n     = s.rst_n;
    frame_start = s.fs;
    pix_valid   = s.valid;
    blank_n_in  = s.blank_n;
    hs_in       = s.hs;
    vs_in       = s.vs;
    fg_idx      = s.fg;
    bg_idx      = s.bg;
    flash_en    = s.fl;
    if (!s.rst_n) begin
      exp_q.delete();
      exp_q.push_back(RST_VEC);
      exp_q.push_back(RST_VEC);
      cnt_m = 6'd0;
    end else begin
      exp_q.push_back({model_rgb(s, cnt_m), s.blank_n, s.hs, s.vs, s.valid});
      if (s.fs) cnt_m = cnt_m + 6'd1;
    end
  endtask

  task automatic test_reset();
    stim_t st[$];
    logic [27:0] e;
    for (int i = 0; i < 4; i++)
      st.push_back(mk(1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                      1'($urandom), 9'($urandom), 9'($urandom), 1'($urandom)));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd1, 9'd7, 0));
    for (int i = 0; i < 3; i++) st.push_back(mk(1, 0, 0, 0, 1, 1, 9'd0, 9'd0, 0));
    foreach (st[i]) begin
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL reset[%0d] got=%h exp=%h", i, obs, e);
        else n_pass++;
      end
      drive(st[i]);
      if (!st[i].rst_n) begin
        #1;
        n_total++;
        if (obs !== RST_VEC) $display("FAIL reset_hold[%0d] got=%h exp=%h", i, obs, RST_VEC);
        else n_pass++;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_transparency();
    stim_t st[$];
    logic [27:0] e;
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd0,  9'd13, 0));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd0,  9'd0,  0));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd13, 9'd1,  0));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd0,  9'd1,  1));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd0,  9'd300, 0));
    foreach (st[i]) begin
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL transp[%0d] got=%h exp=%h", i, obs, e);
        else n_pass++;
      end
      drive(st[i]);
      @(negedge Clk);
    end
  endtask

  task automatic test_invalid_index();
    stim_t st[$];
    logic [27:0] e;
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd506, 9'd13, 0));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd511, 9'd13, 0));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd505, 9'd0,  0));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd0,   9'd510, 0));
    foreach (st[i]) begin
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL invalid_idx[%0d] got=%h exp=%h", i, obs, e);
        else n_pass++;
      end
      drive(st[i]);
      @(negedge Clk);
    end
  endtask

  task automatic test_flash();
    stim_t st[$];
    logic [27:0] e;
    // count 0..6 -> 7, then a pixel coincident with the 8th pulse sees 7
    for (int i = 0; i < 7; i++) st.push_back(mk(1, 1, 0, 1, 1, 1, 9'd0, 9'd0, 0));
    st.push_back(mk(1, 1, 1, 1, 1, 1, 9'd41, 9'd0, 1));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd41, 9'd0, 1));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd0,  9'd41, 1));
    // 8 -> 15, coincident pixel sees 15 (flash), then 16 (no flash)
    for (int i = 0; i < 7; i++) st.push_back(mk(1, 1, 0, 1, 1, 1, 9'd0, 9'd0, 0));
    st.push_back(mk(1, 1, 1, 1, 1, 1, 9'd41, 9'd0, 1));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd41, 9'd0, 1));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd41, 9'd0, 0));
    foreach (st[i]) begin
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL flash[%0d] got=%h exp=%h", i, obs, e);
        else n_pass++;
      end
      drive(st[i]);
      @(negedge Clk);
    end
  endtask

  task automatic test_blank_sync();
    stim_t st[$];
    logic [27:0] e;
    st.push_back(mk(1, 0, 1, 0, 1, 1, 9'd25, 9'd0, 0));
    st.push_back(mk(1, 0, 1, 1, 1, 1, 9'd25, 9'd0, 0));
    for (int i = 0; i < 8; i++)
      st.push_back(mk(1, 0, 1'(i % 3 != 0), 1'(i < 6), 1'(i % 2), 1'((i / 2) % 2),
                      9'(25 + i), 9'd0, 0));
    foreach (st[i]) begin
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL blank_sync[%0d] got=%h exp=%h", i, obs, e);
        else n_pass++;
      end
      drive(st[i]);
      @(negedge Clk);
    end
  endtask

  task automatic test_mid_reset();
    stim_t st[$];
    logic [27:0] e;
    for (int i = 0; i < 10; i++)
      st.push_back(mk(1'(i != 4), 1'(i == 2), 1, 1, 1'(i % 2), 1, 9'(2 + i), 9'd0, 0));
    foreach (st[i]) begin
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL mid_reset[%0d] got=%h exp=%h", i, obs, e);
        else n_pass++;
      end
      drive(st[i]);
      if (!st[i].rst_n) begin
        #1;
        n_total++;
        if (obs !== RST_VEC) $display("FAIL mid_reset_async got=%h exp=%h", obs, RST_VEC);
        else n_pass++;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_back_to_back();
    stim_t st[$];
    logic [27:0] e;
    for (int i = 0; i < 60; i++)
      st.push_back(mk(1, 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) != 0),
                      1'($urandom_range(0, 7) != 0), 1'($urandom), 1'($urandom),
                      ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom),
                      9'($urandom), 1'($urandom)));
    // two idle cycles flush the last real pixels out of the pipeline
    st.push_back(mk(1, 0, 0, 0, 1, 1, 9'd0, 9'd0, 0));
    st.push_back(mk(1, 0, 0, 0, 1, 1, 9'd0, 9'd0, 0));
    st.push_back(mk(1, 0, 0, 0, 1, 1, 9'd0, 9'd0, 0));
    foreach (st[i]) begin
      if (exp_q.size() == 2) begin
        e = exp_q.pop_front();
        n_total++;
        if (obs !== e) $display("FAIL b2b[%0d] got=%h exp=%h", i, obs, e);
        else n_pass++;
      end
      drive(st[i]);
      @(negedge Clk);
    end
  endtask

  initial begin
    for (int i = 0; i < 506; i++)
      pal_m[i] = {8'(i * 7), 8'(i * 13 + 5), 8'(i * 29 + 11)};
    pal_m[1]  = {8'd52,  8'd73,  8'd72};
    pal_m[13] = {8'd169, 8'd171, 8'd168};
    pal_m[41] = {8'd254, 8'd255, 8'd252};
    for (int i = 0; i < 506; i++) begin
      palette[i][0] = pal_m[i][23:16];
      palette[i][1] = pal_m[i][15:8];
      palette[i][2] = pal_m[i][7:0];
    end
    cnt_m = 6'd0;
    drive(mk(0, 0, 0, 0, 1, 1, 9'd0, 9'd0, 0));
    @(negedge Clk);

    test_reset();
    test_transparency();
    test_invalid_index();
    test_flash();
    test_blank_sync();
    test_mid_reset();
    test_back_to_back();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
